vector_serializer: RTL and testbench
====================================

# vector_serializer

Converts one wide vector (ELEM_NUM packed elements) into a stream of ELEM_NUM single-element transfers, each tagged with its index and a last flag. It sits directly upstream of the 4-way fifo splitter in the backpropagation datapath: layer outputs and errors arrive as full vectors and must be fanned out element by element to the weight-update, delta and activation-derivative consumers. Both sides use valid/ready handshakes. A transfer occurs on a rising clk edge where valid and ready are both high.

## Interface
- ELEM_WIDTH, 16, bits per element
- ELEM_NUM, 8, elements per vector (>= 1)
- ADDR_WIDTH, 3, index width; must satisfy 2^ADDR_WIDTH >= ELEM_NUM

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- vector_in  in  ELEM_NUM*ELEM_WIDTH  packed vector; element i = bits [i*ELEM_WIDTH +: ELEM_WIDTH]
- vector_in_valid  in  1  vector_in is valid
- vector_in_ready  out  1  block can accept a vector
- elem_out  out  ELEM_WIDTH  current element
- elem_out_index  out  ADDR_WIDTH  index of elem_out within its vector
- elem_out_last  out  1  elem_out is element ELEM_NUM-1
- elem_out_valid  out  1  elem_out/index/last are valid
- elem_out_ready  in  1  downstream (splitter data_in_ready) accepts

## Operation
- State: buffer (ELEM_NUM*ELEM_WIDTH), counter (ADDR_WIDTH), FSM {IDLE, SEND}.
- Reset (async, on rst rising, held while rst=1): FSM=IDLE, counter=0, buffer=0. All outputs are 0 while rst=1, including vector_in_ready. After release, vector_in_ready=1, elem_out_valid=0, elem_out=0, elem_out_index=0, elem_out_last=0.
- IDLE: vector_in_ready=1, elem_out_valid=0. On a vector_in handshake: buffer<=vector_in, counter<=0, FSM<=SEND.
- SEND: vector_in_ready=0, elem_out_valid=1, elem_out=buffer element[counter], elem_out_index=counter, elem_out_last=(counter==ELEM_NUM-1).
  - Handshake with last=0: counter<=counter+1.
  - Handshake with last=1: counter<=0, FSM<=IDLE.
  - No handshake: all outputs hold exactly.
- Outputs are functions of registered state only; there is no combinational path from vector_in or elem_out_ready to any output.
- vector_in may change freely while in SEND and must not affect the outputs.
- ELEM_NUM=1: every element has last=1 and index=0.
- Counter never exceeds ELEM_NUM-1. No wrap occurs when ELEM_NUM < 2^ADDR_WIDTH.
- elem_out_index and elem_out_last are 0 whenever elem_out_valid=0. elem_out holds its last value (0 after reset).

## Timing
- Latency: vector handshake at edge T. Element 0 is valid from just after T and is first transferable at edge T+1.
- With elem_out_ready held high, elements 0..ELEM_NUM-1 transfer on edges T+1..T+ELEM_NUM. vector_in_ready returns high after edge T+ELEM_NUM.
- The next vector is accepted at edge T+ELEM_NUM+1 at the earliest. Peak throughput is one vector per ELEM_NUM+1 cycles.
- Backpressure: each cycle elem_out_ready=0 adds one cycle. No element is dropped or duplicated.
- rst asserted mid-vector: elem_out_valid falls immediately, without waiting for clk, and the remaining elements are discarded. After release, the block is in IDLE with an empty buffer.

## Test plan
- Reset: assert rst asynchronously between edges -> outputs go to 0 before the next edge. After release -> vector_in_ready=1, elem_out_valid=0.
- Single vector, no backpressure, ELEM_WIDTH=16, ELEM_NUM=8, vector elements 0x0011..0x0088 -> elem_out 0x0011..0x0088 on 8 consecutive edges, index 0..7, last=1 only on 0x0088, vector_in_ready=0 during transfer then 1.
- Random backpressure (elem_out_ready ~50%) over 100 random vectors -> scoreboard matches every element in order, and outputs are stable while valid=1 and ready=0.
- Input disturbance: change vector_in and hold vector_in_valid=1 during SEND -> no effect on the outputs. The next vector is captured only when vector_in_ready=1.
- Reset mid-vector after element 3 of 8 -> valid drops at once. The next vector then starts at index 0, and none of the old elements 4..7 appear.
- ELEM_NUM=1 build, vectors 0xAAAA then 0x5555 back-to-back -> each emitted with index=0, last=1, and the vectors are accepted 2 cycles apart.

Source files
------------

// File: rtl/vector_serializer.sv
// vector_serializer: unpacks one wide vector into a stream of single
// elements tagged with index and last flag, valid/ready on both sides.
module vector_serializer #(
    parameter int ELEM_WIDTH = 16,
    parameter int ELEM_NUM   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ELEM_NUM*ELEM_WIDTH-1:0] vector_in,
    input  logic                           vector_in_valid,
    output logic                           vector_in_ready,
    output logic [ELEM_WIDTH-1:0]          elem_out,
    output logic [ADDR_WIDTH-1:0]          elem_out_index,
    output logic                           elem_out_last,
    output logic                           elem_out_valid,
    input  logic                           elem_out_ready
);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ELEM_NUM - 1);

    state_e                             state_q, state_d;
    logic [ADDR_WIDTH-1:0]              cnt_q, cnt_d;
    logic [ELEM_NUM-1:0][ELEM_WIDTH-1:0] buf_q, buf_d;
    logic [ELEM_WIDTH-1:0]              elem_q, elem_d;

    logic                  is_last;
    logic                  in_hs;
    logic                  out_hs;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    assign is_last = (cnt_q == LAST_IDX);
    assign in_hs   = (state_q == IDLE) && vector_in_valid;
    assign out_hs  = (state_q == SEND) && elem_out_ready;
    assign cnt_nxt = cnt_q + 1'b1;

    // State, counter, buffer and the held output element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            elem_q  <= elem_d;
        end
    end

    // Next-state: capture a vector in IDLE, step through elements in SEND.
    // elem_q is loaded ahead of time so elem_out stays registered and
    // keeps its final value once the vector is drained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        elem_d  = elem_q;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    buf_d   = vector_in;
                    cnt_d   = '0;
                    elem_d  = vector_in[ELEM_WIDTH-1:0];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_nxt;
                        elem_d = buf_q[cnt_nxt];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst so it reads 0 for the whole reset pulse.
    assign vector_in_ready = (state_q == IDLE) && !rst;
    assign elem_out_valid  = (state_q == SEND);
    assign elem_out        = elem_q;
    assign elem_out_index  = elem_out_valid ? cnt_q : '0;
    assign elem_out_last   = elem_out_valid && is_last;

endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer: directed checks of vector_serializer, plus a
// ELEM_NUM=1 instance for the back-to-back single-element case.
module tb_vector_serializer;

    logic         clk;
    logic         rst;
    logic [127:0] vin;
    logic         vin_valid;
    logic         vin_ready;
    logic [15:0]  eo;
    logic [2:0]   eidx;
    logic         elast;
    logic         evalid;
    logic         erdy;

    logic [15:0]  vin1;
    logic         vin1_valid;
    logic         vin1_ready;
    logic [15:0]  eo1;
    logic [0:0]   eidx1;
    logic         elast1;
    logic         evalid1;
    logic         erdy1;

    int errors = 0;
    int checks = 0;

    vector_serializer #(
        .ELEM_WIDTH(16),
        .ELEM_NUM  (8),
        .ADDR_WIDTH(3)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .vector_in      (vin),
        .vector_in_valid(vin_valid),
        .vector_in_ready(vin_ready),
        .elem_out       (eo),
        .elem_out_index (eidx),
        .elem_out_last  (elast),
        .elem_out_valid (evalid),
        .elem_out_ready (erdy)
    );

    vector_serializer #(
        .ELEM_WIDTH(16),
        .ELEM_NUM  (1),
        .ADDR_WIDTH(1)
    ) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .vector_in      (vin1),
        .vector_in_valid(vin1_valid),
        .vector_in_ready(vin1_ready),
        .elem_out       (eo1),
        .elem_out_index (eidx1),
        .elem_out_last  (elast1),
        .elem_out_valid (evalid1),
        .elem_out_ready (erdy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ev [8];
    logic [15:0] s_eo;
    logic [2:0]  s_idx;
    logic        s_last;

    initial begin
        rst        = 1'b0;
        vin        = '0;
        vin_valid  = 1'b0;
        erdy       = 1'b0;
        vin1       = '0;
        vin1_valid = 1'b0;
        erdy1      = 1'b0;

        // reset asserted between edges
        #3 rst = 1'b1;
        #1;
        chk("rst_vready", 32'(vin_ready), 0);
        chk("rst_valid", 32'(evalid), 0);
        chk("rst_elem", 32'(eo), 0);
        chk("rst_idx", 32'(eidx), 0);
        chk("rst_last", 32'(elast), 0);
        chk("rst_vready1", 32'(vin1_ready), 0);
        step();
        step();
        chk("rst_hold_vready", 32'(vin_ready), 0);
        #2 rst = 1'b0;
        #1;
        chk("rel_vready", 32'(vin_ready), 1);
        chk("rel_valid", 32'(evalid), 0);
        chk("rel_elem", 32'(eo), 0);
        chk("rel_idx", 32'(eidx), 0);

        // single vector, no backpressure
        for (int i = 0; i < 8; i++) begin
            ev[i] = 16'(17 * (i + 1));
            vin[i*16 +: 16] = ev[i];
        end
        vin_valid = 1'b1;
        erdy      = 1'b1;
        step();
        vin_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("sv_valid", 32'(evalid), 1);
            chk("sv_vready", 32'(vin_ready), 0);
            chk("sv_elem", 32'(eo), 32'(ev[i]));
            chk("sv_idx", 32'(eidx), i);
            chk("sv_last", 32'(elast), (i == 7) ? 1 : 0);
            step();
        end
        chk("sv_end_vready", 32'(vin_ready), 1);
        chk("sv_end_valid", 32'(evalid), 0);
        chk("sv_end_elem", 32'(eo), 32'h88);
        chk("sv_end_idx", 32'(eidx), 0);
        chk("sv_end_last", 32'(elast), 0);

        // input disturbance while sending, stalled then draining
        for (int i = 0; i < 8; i++) begin
            ev[i] = 16'(32'h1000 + i);
            vin[i*16 +: 16] = ev[i];
        end
        vin_valid = 1'b1;
        erdy      = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            vin = {$urandom, $urandom, $urandom, $urandom};
            chk("dist_stall_elem", 32'(eo), 32'h1000);
            chk("dist_stall_idx", 32'(eidx), 0);
            chk("dist_stall_vready", 32'(vin_ready), 0);
            step();
        end
        for (int i = 0; i < 8; i++)
            vin[i*16 +: 16] = 16'(32'h2000 + i);
        erdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("dist_a_elem", 32'(eo), 32'(ev[i]));
            chk("dist_a_idx", 32'(eidx), i);
            step();
        end
        chk("dist_idle_vready", 32'(vin_ready), 1);
        chk("dist_idle_valid", 32'(evalid), 0);
        step();
        vin_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("dist_b_elem", 32'(eo), 32'h2000 + i);
            chk("dist_b_idx", 32'(eidx), i);
            chk("dist_b_last", 32'(elast), (i == 7) ? 1 : 0);
            step();
        end

        // reset in the middle of a vector
        for (int i = 0; i < 8; i++)
            vin[i*16 +: 16] = 16'(32'h3000 + i);
        vin_valid = 1'b1;
        step();
        vin_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mr_elem", 32'(eo), 32'h3000 + i);
            step();
        end
        chk("mr_pre_idx", 32'(eidx), 4);
        #3 rst = 1'b1;
        #1;
        chk("mr_valid", 32'(evalid), 0);
        chk("mr_vready", 32'(vin_ready), 0);
        chk("mr_idx", 32'(eidx), 0);
        chk("mr_elem0", 32'(eo), 0);
        step();
        #2 rst = 1'b0;
        #1;
        chk("mr_rel_vready", 32'(vin_ready), 1);
        chk("mr_rel_valid", 32'(evalid), 0);
        chk("mr_rel_elem", 32'(eo), 0);
        for (int i = 0; i < 8; i++)
            vin[i*16 +: 16] = 16'(32'h4000 + i);
        vin_valid = 1'b1;
        step();
        vin_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mr_d_elem", 32'(eo), 32'h4000 + i);
            chk("mr_d_idx", 32'(eidx), i);
            step();
        end
        chk("mr_d_done", 32'(evalid), 0);

        // random backpressure over 100 random vectors
        for (int v = 0; v < 100; v++) begin
            int k;
            int guard;
            for (int i = 0; i < 8; i++) begin
                ev[i] = 16'($urandom);
                vin[i*16 +: 16] = ev[i];
            end
            chk("rnd_vready", 32'(vin_ready), 1);
            vin_valid = 1'b1;
            step();
            vin_valid = 1'b0;
            k     = 0;
            guard = 0;
            while (k < 8 && guard < 200) begin
                guard++;
                erdy   = 1'($urandom_range(0, 1));
                s_eo   = eo;
                s_idx  = eidx;
                s_last = elast;
                if (erdy) begin
                    chk("rnd_valid", 32'(evalid), 1);
                    chk("rnd_elem", 32'(eo), 32'(ev[k]));
                    chk("rnd_idx", 32'(eidx), k);
                    chk("rnd_last", 32'(elast), (k == 7) ? 1 : 0);
                    k++;
                    step();
                end else begin
                    step();
                    chk("rnd_hold_valid", 32'(evalid), 1);
                    chk("rnd_hold_elem", 32'(eo), 32'(s_eo));
                    chk("rnd_hold_idx", 32'(eidx), 32'(s_idx));
                    chk("rnd_hold_last", 32'(elast), 32'(s_last));
                end
            end
            chk("rnd_done", k, 8);
        end
        erdy = 1'b1;

        // ELEM_NUM=1 build, back-to-back vectors
        vin1       = 16'hAAAA;
        vin1_valid = 1'b1;
        erdy1      = 1'b1;
        step();
        chk("n1_a_valid", 32'(evalid1), 1);
        chk("n1_a_elem", 32'(eo1), 32'hAAAA);
        chk("n1_a_idx", 32'(eidx1), 0);
        chk("n1_a_last", 32'(elast1), 1);
        chk("n1_a_vready", 32'(vin1_ready), 0);
        vin1 = 16'h5555;
        step();
        chk("n1_gap_vready", 32'(vin1_ready), 1);
        chk("n1_gap_valid", 32'(evalid1), 0);
        step();
        vin1_valid = 1'b0;
        chk("n1_b_valid", 32'(evalid1), 1);
        chk("n1_b_elem", 32'(eo1), 32'h5555);
        chk("n1_b_idx", 32'(eidx1), 0);
        chk("n1_b_last", 32'(elast1), 1);
        step();
        chk("n1_end_valid", 32'(evalid1), 0);
        chk("n1_end_elem", 32'(eo1), 32'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
